// File: rtl/deflation_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : deflation_sequencer_if
// Purpose  : Bundles the run-control, engine handshake and matrix-control
//            signals of the deflation sequencer.
// Ports    : (interface signals)
//   start, num_comp        run request and component count
//   eig_start, eig_done    eigenvector engine handshake
//   vec_wr_en, vec_wr_idx  eigenvector/eigenvalue store strobe and slot
//   upd_start, upd_done    covariance updater handshake
//   cov_sel, cov_load      working-matrix select and deflated-matrix latch
//   comp_idx, busy, done, timeout_err   status
// Modports : master = sequencer side, slave = environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface deflation_sequencer_if #(
  parameter int IDX_W = 3
);
  logic             start;
  logic [IDX_W:0]   num_comp;
  logic             eig_start;
  logic             eig_done;
  logic             vec_wr_en;
  logic [IDX_W-1:0] vec_wr_idx;
  logic             upd_start;
  logic             upd_done;
  logic             cov_sel;
  logic             cov_load;
  logic [IDX_W-1:0] comp_idx;
  logic             busy;
  logic             done;
  logic             timeout_err;

  modport master (
    input  start, num_comp, eig_done, upd_done,
    output eig_start, vec_wr_en, vec_wr_idx, upd_start, cov_sel, cov_load,
           comp_idx, busy, done, timeout_err
  );

  modport slave (
    output start, num_comp, eig_done, upd_done,
    input  eig_start, vec_wr_en, vec_wr_idx, upd_start, cov_sel, cov_load,
           comp_idx, busy, done, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/deflation_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : deflation_sequencer
// Purpose  : Eigen-decomposition-by-deflation controller. For each of K
//            components: start the eigenvector engine, store its result,
//            run the covariance updater, reload the deflated matrix.
// Ports    :
//   clk   in  system clock, rising edge
//   rst   in  synchronous reset, active low
//   bus   deflation_sequencer_if.master (handshakes, strobes, status)
// Revision : 1.0 - initial release
// ============================================================================
module deflation_sequencer #(
  parameter int MAX_COMP = 8,
  parameter int IDX_W    = 3,
  parameter int TIMEOUT  = 4096,
  parameter int TO_W     = 13
) (
  input wire clk,
  input wire rst,
  deflation_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EIG_GO   = 3'd1,
    S_EIG_WAIT = 3'd2,
    S_STORE    = 3'd3,
    S_UPD_WAIT = 3'd4,
    S_LOAD     = 3'd5,
    S_NEXT     = 3'd6,
    S_FIN      = 3'd7
  } state_t;

  localparam logic [IDX_W:0]   C_MAX_COMP = (IDX_W+1)'(MAX_COMP);
  localparam logic [IDX_W:0]   C_K_ONE    = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
  localparam logic [TO_W-1:0]  C_TIMEOUT  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  C_CNT_ONE  = TO_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W:0]   k_q, k_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             terr_q, terr_d;
  logic             bad_q, bad_d;     // done pulse for a rejected start
  logic             legal_w;
  logic             last_w;
  logic [TO_W-1:0]  cnt_inc_w;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    terr_d    = terr_q;
    bad_d     = 1'b0;
    legal_w   = (bus.num_comp != '0) && (bus.num_comp <= C_MAX_COMP);
    last_w    = ({1'b0, idx_q} == (k_q - C_K_ONE));
    cnt_inc_w = cnt_q + C_CNT_ONE;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (legal_w) begin
            k_d     = bus.num_comp;
            idx_d   = '0;
            sel_d   = 1'b0;
            terr_d  = 1'b0;
            state_d = S_EIG_GO;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      S_EIG_GO: begin
        cnt_d   = '0;
        state_d = S_EIG_WAIT;
      end
      S_EIG_WAIT: begin
        if (bus.eig_done) begin
          state_d = S_STORE;
        end else begin
          cnt_d = cnt_inc_w;
          if (cnt_inc_w >= C_TIMEOUT) begin
            terr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_STORE: begin
        // The final component is never deflated.
        if (last_w) begin
          state_d = S_FIN;
        end else begin
          cnt_d   = '0;
          state_d = S_UPD_WAIT;
        end
      end
      S_UPD_WAIT: begin
        if (bus.upd_done) begin
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_inc_w;
          if (cnt_inc_w >= C_TIMEOUT) begin
            terr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        // From here on the engine works on the deflated register.
        sel_d   = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        idx_d   = idx_q + C_IDX_ONE;
        state_d = S_EIG_GO;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      terr_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      terr_q  <= terr_d;
      bad_q   <= bad_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output
  // without passing through a flop.
  assign bus.eig_start   = (state_q == S_EIG_GO);
  assign bus.vec_wr_en   = (state_q == S_STORE);
  assign bus.vec_wr_idx  = idx_q;
  assign bus.upd_start   = (state_q == S_UPD_WAIT);
  assign bus.cov_load    = (state_q == S_LOAD);
  assign bus.cov_sel     = sel_q;
  assign bus.comp_idx    = idx_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_FIN) | bad_q;
  assign bus.timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_deflation_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_deflation_sequencer
// Purpose  : Randomised scoreboard bench for deflation_sequencer. Each run
//            is turned into a timed list of expected output events from the
//            per-component latency rules; a monitor matches DUT events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deflation_sequencer;

  localparam int IDX_W = 3;
  localparam int MAXC  = 8;
  localparam int TO    = 16;

  localparam int EV_EIG  = 0;
  localparam int EV_WR   = 1;
  localparam int EV_UPD  = 2;
  localparam int EV_LOAD = 3;
  localparam int EV_DONE = 4;
  localparam int EV_TERR = 5;

  typedef struct {
    int kind;
    int idx;
    int cyc;
    bit sel;
    bit busy;
    bit terr;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  ev_t exp_q[$];
  int  eig_lat_q[$];
  int  upd_lat_q[$];

  // Reference-model state carried between runs.
  int  m_idx  = 0;
  bit  m_sel  = 0;
  bit  m_terr = 0;

  deflation_sequencer_if #(.IDX_W(IDX_W)) bus ();

  deflation_sequencer #(
    .MAX_COMP (MAXC),
    .IDX_W    (IDX_W),
    .TIMEOUT  (TO),
    .TO_W     (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic push(input int kind, input int idx, input int c,
                      input bit sel, input bit busy, input bit terr);
    ev_t e;
    e.kind = kind; e.idx = idx; e.cyc = c;
    e.sel = sel; e.busy = busy; e.terr = terr;
    exp_q.push_back(e);
  endtask

  task automatic mon_check(input int kind, input int idx);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL ev_unexpected: got kind=%0d idx=%0d cyc=%0d want no event",
               kind, idx, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.idx != idx || e.cyc != cyc ||
        e.sel != bus.cov_sel || e.busy != bus.busy || e.terr != bus.timeout_err) begin
      bad++;
      $display("FAIL ev: got kind=%0d idx=%0d cyc=%0d sel=%0d busy=%0d terr=%0d want kind=%0d idx=%0d cyc=%0d sel=%0d busy=%0d terr=%0d",
               kind, idx, cyc, bus.cov_sel, bus.busy, bus.timeout_err,
               e.kind, e.idx, e.cyc, e.sel, e.busy, e.terr);
    end
  endtask

  // Monitor: every visible DUT action is one scoreboard event.
  initial begin
    bit pupd;
    bit pterr;
    pupd = 0;
    pterr = 0;
    forever begin
      @(negedge clk);
      if (bus.eig_start === 1'b1) mon_check(EV_EIG, int'(bus.comp_idx));
      if (bus.vec_wr_en === 1'b1) mon_check(EV_WR, int'(bus.vec_wr_idx));
      if (bus.upd_start === 1'b1 && !pupd) mon_check(EV_UPD, int'(bus.comp_idx));
      if (bus.cov_load === 1'b1) mon_check(EV_LOAD, int'(bus.comp_idx));
      if (bus.done === 1'b1) mon_check(EV_DONE, int'(bus.comp_idx));
      if (bus.timeout_err === 1'b1 && !pterr) mon_check(EV_TERR, int'(bus.comp_idx));
      pupd  = (bus.upd_start === 1'b1);
      pterr = (bus.timeout_err === 1'b1);
    end
  end

  // Eigenvector engine: answers L cycles after each eig_start.
  initial begin
    int l;
    bus.eig_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.eig_start === 1'b1) begin
        l = (eig_lat_q.size() != 0) ? eig_lat_q.pop_front() : 0;
        if (l > 0) begin
          repeat (l) @(posedge clk);
          #1 bus.eig_done = 1'b1;
          @(posedge clk);
          #1 bus.eig_done = 1'b0;
        end
      end
    end
  end

  // Covariance updater: answers M cycles after upd_start rises; 0 = never.
  initial begin
    int m;
    bit prev;
    prev = 0;
    bus.upd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.upd_start === 1'b1 && !prev) begin
        m = (upd_lat_q.size() != 0) ? upd_lat_q.pop_front() : 0;
        if (m > 0) begin
          repeat (m) @(posedge clk);
          #1 bus.upd_done = 1'b1;
          @(posedge clk);
          #1 bus.upd_done = 1'b0;
        end
      end
      prev = (bus.upd_start === 1'b1);
    end
  end

  // mode: 0 normal, 1 updater never answers on component 0,
  //       2 reset during UPD_WAIT of component 1, 3 start pulsed mid-run.
  // fl/fm: fixed engine latencies, 0 selects random 1..12.
  task automatic run(input int k, input int mode, input int fl, input int fm);
    int s, c, w, u, l, m, n;
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.num_comp = 4'(k);
    s = cyc;
    if (k < 1 || k > MAXC) begin
      push(EV_DONE, m_idx, s + 1, m_sel, 0, m_terr);
    end else begin
      c = s + 1;
      m_terr = 0;
      for (int i = 0; i < k; i++) begin
        l = (fl > 0) ? fl : int'($urandom_range(1, 12));
        eig_lat_q.push_back(l);
        push(EV_EIG, i, c, i > 0, 1, 0);
        w = c + l + 1;
        push(EV_WR, i, w, i > 0, 1, 0);
        if (i == k - 1) begin
          push(EV_DONE, i, w + 1, k > 1, 1, 0);
          m_idx = i;
          m_sel = (k > 1);
        end else begin
          u = w + 1;
          push(EV_UPD, i, u, i > 0, 1, 0);
          if (mode == 1) begin
            upd_lat_q.push_back(0);
            push(EV_TERR, 0, u + TO, 0, 0, 1);
            m_idx = 0; m_sel = 0; m_terr = 1;
            break;
          end
          if (mode == 2 && i == 1) begin
            upd_lat_q.push_back(30);
            break;
          end
          m = (fm > 0) ? fm : int'($urandom_range(1, 12));
          upd_lat_q.push_back(m);
          push(EV_LOAD, i, u + m + 1, i > 0, 1, 0);
          c = u + m + 3;
        end
      end
    end
    @(posedge clk);
    #1 bus.start = 1'b0;

    if (mode == 3) begin
      repeat (18) @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.num_comp = 4'd5;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end

    if (mode == 2) begin
      n = 0;
      while (n < 500 && !(bus.upd_start === 1'b1 && bus.comp_idx == 3'd1)) begin
        @(negedge clk);
        n++;
      end
      chk("rst_reach_upd1", int'(n < 500), 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_upd_start", int'(bus.upd_start), 0);
      chk("rst_comp_idx", int'(bus.comp_idx), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_cov_sel", int'(bus.cov_sel), 0);
      chk("rst_queue_drained", exp_q.size(), 0);
      rst = 1'b1;
      exp_q.delete();
      m_idx = 0; m_sel = 0; m_terr = 0;
      repeat (40) @(posedge clk);
    end else begin
      n = 0;
      while (n < 1500 && (exp_q.size() != 0 || bus.busy === 1'b1)) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1500) begin
        total++;
        bad++;
        $display("FAIL run_timeout: got %0d pending events want 0", exp_q.size());
        exp_q.delete();
      end
      repeat (3) @(posedge clk);
    end
  endtask

  initial begin
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.num_comp = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_eig_start", int'(bus.eig_start), 0);
    chk("reset_vec_wr_en", int'(bus.vec_wr_en), 0);
    chk("reset_vec_wr_idx", int'(bus.vec_wr_idx), 0);
    chk("reset_upd_start", int'(bus.upd_start), 0);
    chk("reset_cov_sel", int'(bus.cov_sel), 0);
    chk("reset_cov_load", int'(bus.cov_load), 0);
    chk("reset_comp_idx", int'(bus.comp_idx), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_timeout_err", int'(bus.timeout_err), 0);
    repeat (2) @(posedge clk);

    run(3, 0, 10, 6);     // nominal K=3
    run(1, 0, 0, 0);      // single component, no deflation
    run(2, 1, 10, 0);     // updater timeout on component 0
    run(0, 0, 0, 0);      // illegal count, error flag must persist
    run(1, 0, 0, 0);      // accepted start clears the error flag
    run(3, 3, 10, 6);     // start during a run is ignored
    run(3, 2, 5, 6);      // reset during component 1 update
    run(MAXC, 0, 0, 0);   // largest legal count
    run(MAXC + 1, 0, 0, 0);
    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(0, 11)), 0, 0, 0);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
